rshift_sched: RTL and testbench

Shared rounding-shift scheduler for the requantization stage. Several requesters, such as per-lane accumulator drains, send 32-bit signed values with a shift exponent. The block arbitrates between them round-robin and runs the winners through one 2-stage pipelined rounding divide-by-2^exp unit. Results return on a single valid/ready output tagged with the requester ID. It sits between the accumulator banks and the output quantizer.

---
 rtl/rshift_sched_if.sv | 56 +++++
 rtl/rshift_sched.sv | 199 +++++++++++++++++++
 tb/tb_rshift_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rshift_sched_if.sv
// -----------------------------------------------------------------------------
// rshift_sched_if
//   Bundles the request and result handshakes of the rounding-shift scheduler.
//
//   req_valid [NUM_REQ]     per-requester operand valid
//   req_ready [NUM_REQ]     per-requester accept (one-hot or zero)
//   req_data  [32*NUM_REQ]  signed dividends, requester i at [32*i +: 32]
//   req_exp   [6*NUM_REQ]   unsigned shift exponents, requester i at [6*i +: 6]
//   out_valid / out_ready   result handshake
//   out_data  [32]          signed rounded quotient
//   out_id    [ID_W]        requester that produced out_data
//   busy                    any pipeline stage occupied
//
//   master : the requester/consumer side (drives operands, accepts results)
//   slave  : the scheduler side
// -----------------------------------------------------------------------------
interface rshift_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_data;
  logic [6*NUM_REQ-1:0]  req_exp;
  logic                  out_valid;
  logic                  out_ready;
  logic [31:0]           out_data;
  logic [ID_W-1:0]       out_id;
  logic                  busy;

  modport master (
    output req_valid,
    output req_data,
    output req_exp,
    output out_ready,
    input  req_ready,
    input  out_valid,
    input  out_data,
    input  out_id,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_exp,
    input  out_ready,
    output req_ready,
    output out_valid,
    output out_data,
    output out_id,
    output busy
  );

endinterface

// File: rtl/rshift_sched.sv
// -----------------------------------------------------------------------------
// rshift_sched
//   Round-robin scheduler in front of a shared 2-stage rounding
//   divide-by-2^exp unit. Requesters offer a signed 32-bit value plus a 6-bit
//   exponent; one winner per cycle enters stage 1, stage 2 holds the rounded
//   quotient and drives the result port directly from registers.
//
//   Rounding: midpoints round away from zero; exponents 32..63 act as 31.
//
// Ports
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : rshift_sched_if.slave (request ports, result port, busy)
// -----------------------------------------------------------------------------
module rshift_sched #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic          clk,
  input  logic          rst,
  rshift_sched_if.slave bus
);

  // Stage-1 payload: raw dividend, clamped exponent, requester tag.
  typedef struct packed {
    logic [31:0]     data;
    logic [4:0]      exp;
    logic [ID_W-1:0] id;
  } s1_entry_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [ID_W-1:0] rr_ptr;
  logic            s1_valid;
  s1_entry_t       s1;
  logic            s2_valid;
  logic [31:0]     s2_data;
  logic [ID_W-1:0] s2_id;

  // ---------------------------------------------------------------------------
  // Pipeline flow control
  // ---------------------------------------------------------------------------
  logic s2_open;   // stage 2 loads this cycle (empty or draining)
  logic s1_open;   // stage 1 can take a new request this cycle
  logic accept;    // a request transfer happens at the next edge

  assign s2_open = !s2_valid || bus.out_ready;
  assign s1_open = !s1_valid || s2_open;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration
  //   Scan downward so the last hit is the lowest index. hi_* tracks the
  //   lowest valid index at or above rr_ptr, lo_* the lowest valid overall;
  //   falling back to lo_* implements the wrap-around.
  // ---------------------------------------------------------------------------
  logic            hi_found;
  logic            lo_found;
  logic [ID_W-1:0] hi_idx;
  logic [ID_W-1:0] lo_idx;
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;

  // NOTE: every always_comb output gets a default before any branch; a path
  // that leaves a variable unassigned would infer a latch.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_found = hi_found || lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Nothing is accepted while reset is held, so req_ready reads zero in reset.
  assign accept = grant_found && s1_open && !rst;

  always_comb begin
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_ready[i] = accept && (grant_idx == ID_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Operand select and exponent clamp
  // ---------------------------------------------------------------------------
  logic [31:0] sel_data;
  logic [5:0]  sel_exp;
  logic [4:0]  sel_exp_clamped;

  always_comb begin
    sel_data = '0;
    sel_exp  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_data = bus.req_data[32*i +: 32];
        sel_exp  = bus.req_exp[6*i +: 6];
      end
    end
    // Any exponent >= 32 shifts every magnitude to 0 or 1, same as 31.
    sel_exp_clamped = sel_exp[5] ? 5'd31 : sel_exp[4:0];
  end

  // ---------------------------------------------------------------------------
  // Rounding divide (between stage 1 and stage 2)
  //   Work on the 33-bit magnitude so -2^31 negates cleanly, add half an LSB
  //   of the result, shift, then restore the sign. For e = 0 the half term is
  //   zero and the value passes through unchanged.
  // ---------------------------------------------------------------------------
  logic        x_neg;
  logic [32:0] x_mag;
  logic [32:0] half;
  logic [32:0] rounded_mag;
  logic [32:0] signed_res;
  logic [31:0] round_res;
  logic        sign_unused;

  always_comb begin
    x_neg       = s1.data[31];
    x_mag       = x_neg ? (33'd0 - {1'b1, s1.data}) : {1'b0, s1.data};
    half        = (s1.exp == 5'd0) ? 33'd0 : (33'd1 << (s1.exp - 5'd1));
    rounded_mag = (x_mag + half) >> s1.exp;
    signed_res  = x_neg ? (33'd0 - rounded_mag) : rounded_mag;
    round_res   = signed_res[31:0];
  end

  // The result always fits in 32 bits signed; bit 32 is only sign extension.
  assign sign_unused = signed_res[32];

  // ---------------------------------------------------------------------------
  // Round-robin pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered operand
  // ---------------------------------------------------------------------------
  // NOTE: the payload registers are reset along with the valid flags because
  // the result port must read all-zero in reset; a true storage array would
  // be left unreset and qualified by its valid bits instead.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_open) begin
      // Either stage 1 was empty or its entry moves on; refill or go empty.
      s1_valid <= accept;
      if (accept) begin
        s1.data <= sel_data;
        s1.exp  <= sel_exp_clamped;
        s1.id   <= grant_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: registered result, drives the output port
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
    end else if (s2_open) begin
      // Loading only when empty or draining keeps the result stable under
      // backpressure.
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= round_res;
        s2_id   <= s1.id;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_id    = s2_id;
  assign bus.busy      = s1_valid || s2_valid;

endmodule

// File: tb/tb_rshift_sched.sv
// -----------------------------------------------------------------------------
// tb_rshift_sched
//   Directed bench for rshift_sched (NUM_REQ = 4). Inputs change 1 ns after a
//   rising edge; outputs and the combinational req_ready are sampled on the
//   falling edge, i.e. the values that take part in the next rising edge.
//   A request shown ready at negedge k transfers at the next edge; its result
//   is visible at negedge k+2 and transfers at the edge after that.
// -----------------------------------------------------------------------------
module tb_rshift_sched;

  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;

  rshift_sched_if #(.NUM_REQ(N), .ID_W(IW)) bus ();

  rshift_sched #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // One isolated request through the pipeline with exact-latency checks.
  // ---------------------------------------------------------------------------
  task automatic do_single(input int id, input logic [31:0] x, input logic [5:0] e,
                           input logic [31:0] expv, input string name);
    logic [N-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    @(posedge clk); #1;
    bus.req_valid              = '0;
    bus.req_valid[id]          = 1'b1;
    bus.req_data[32*id +: 32]  = x;
    bus.req_exp[6*id +: 6]     = e;
    bus.out_ready              = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== oh) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, bus.req_ready, oh);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_early: out_valid got %b expected 0", name, bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid: got %b expected 1", name, bus.out_valid);
    end
    checks++;
    if (bus.out_data !== expv) begin
      errors++;
      $display("FAIL %s_data: got %h expected %h", name, bus.out_data, expv);
    end
    checks++;
    if (bus.out_id !== IW'(id)) begin
      errors++;
      $display("FAIL %s_id: got %0d expected %0d", name, bus.out_id, id);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst           = 1'b1;
    bus.req_valid = '1;
    bus.req_data  = {32'd40, 32'd30, 32'd20, 32'd10};
    bus.req_exp   = '0;
    bus.out_ready = 1'b1;
    #3;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.out_data !== 32'd0) begin errors++; $display("FAIL rst_out_data: got %h expected 0", bus.out_data); end
    checks++;
    if (bus.out_id !== 2'd0) begin errors++; $display("FAIL rst_out_id: got %0d expected 0", bus.out_id); end
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    checks++;
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_req_ready: got %b expected 0000", bus.req_ready); end
    // Held across edges with requests pending: nothing may enter.
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_hold: busy %b out_valid %b expected 0 0", bus.busy, bus.out_valid);
    end
    bus.req_valid = '0;
    rst           = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single();
    do_single(0, 32'd7,          6'd1, 32'd4,          "single_p7");
    do_single(0, -32'sd7,        6'd1, -32'sd4,        "single_m7");
    do_single(0, 32'd5,          6'd2, 32'd1,          "single_p5");
  endtask

  // ---------------------------------------------------------------------------
  // All through requester 3 so rr_ptr ends at 0 for the next test.
  task automatic test_boundary();
    logic [31:0] bx [8];
    logic [5:0]  be [8];
    logic [31:0] br [8];
    bx[0] = 32'h8000_0000; be[0] = 6'd0;  br[0] = 32'h8000_0000;
    bx[1] = 32'h7FFF_FFFF; be[1] = 6'd1;  br[1] = 32'h4000_0000;
    bx[2] = 32'hFFFF_FFFF; be[2] = 6'd1;  br[2] = 32'hFFFF_FFFF;
    bx[3] = 32'h0000_0001; be[3] = 6'd40; br[3] = 32'h0000_0000;
    bx[4] = 32'h4000_0000; be[4] = 6'd31; br[4] = 32'h0000_0001;
    bx[5] = 32'h8000_0000; be[5] = 6'd31; br[5] = 32'hFFFF_FFFF;
    bx[6] = 32'h7FFF_FFFF; be[6] = 6'd63; br[6] = 32'h0000_0001;
    bx[7] = 32'hFFFF_FFFA; be[7] = 6'd2;  br[7] = 32'hFFFF_FFFE;
    for (int i = 0; i < 8; i++) begin
      do_single(3, bx[i], be[i], br[i], $sformatf("bound%0d", i));
    end
  endtask

  // ---------------------------------------------------------------------------
  // Streaming data shared by the multi-requester tests (exp = 1).
  function automatic logic [31:0] stream_x(input int i);
    case (i)
      0: return 32'd1001;
      1: return 32'd2001;
      2: return -32'sd3001;
      default: return 32'd4001;
    endcase
  endfunction

  function automatic logic [31:0] stream_r(input int i);
    case (i)
      0: return 32'd501;
      1: return 32'd1001;
      2: return -32'sd1501;
      default: return 32'd2001;
    endcase
  endfunction

  task automatic load_stream();
    for (int i = 0; i < N; i++) begin
      bus.req_data[32*i +: 32] = stream_x(i);
      bus.req_exp[6*i +: 6]    = 6'd1;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_round_robin_all();
    logic [N-1:0] oh;
    int           oid;
    @(posedge clk); #1;
    load_stream();
    bus.out_ready = 1'b1;
    bus.req_valid = '1;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k < 12) begin
        oh = '0;
        oh[k % N] = 1'b1;
        checks++;
        if (bus.req_ready !== oh) begin
          errors++;
          $display("FAIL rr_all_grant%0d: got %b expected %b", k, bus.req_ready, oh);
        end
      end
      if (k >= 2) begin
        oid = (k - 2) % N;
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== IW'(oid) || bus.out_data !== stream_r(oid)) begin
          errors++;
          $display("FAIL rr_all_out%0d: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
                   k, bus.out_valid, bus.out_id, bus.out_data, oid, stream_r(oid));
        end
      end
      if (k == 11) begin
        @(posedge clk); #1;
        bus.req_valid = '0;
      end
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rr_all_empty: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    int accepts;
    accepts = 0;
    @(posedge clk); #1;
    load_stream();
    bus.out_ready = 1'b0;
    bus.req_valid = '1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      accepts += $countones(bus.req_valid & bus.req_ready);
      if (k >= 2) begin
        checks++;
        if (bus.req_ready !== 4'b0000) begin
          errors++;
          $display("FAIL bp_ready%0d: got %b expected 0000", k, bus.req_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== stream_r(0)) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b id=%0d data=%h expected v=1 id=0 data=%h",
                   k, bus.out_valid, bus.out_id, bus.out_data, stream_r(0));
        end
      end
    end
    checks++;
    if (accepts != 2) begin
      errors++;
      $display("FAIL bp_accepts: got %0d expected 2", accepts);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd0 || bus.out_data !== stream_r(0)) begin
      errors++;
      $display("FAIL bp_drain0: got v=%b id=%0d data=%h expected v=1 id=0 data=%h",
               bus.out_valid, bus.out_id, bus.out_data, stream_r(0));
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd1 || bus.out_data !== stream_r(1)) begin
      errors++;
      $display("FAIL bp_drain1: got v=%b id=%0d data=%h expected v=1 id=1 data=%h",
               bus.out_valid, bus.out_id, bus.out_data, stream_r(1));
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Entered with rr_ptr = 2 (last accept in the previous test was requester 1).
  task automatic test_rr_sparse();
    logic [3:0]  exp_grant [3];
    logic [1:0]  exp_id    [3];
    logic [31:0] exp_data  [3];
    exp_grant[0] = 4'b1000; exp_grant[1] = 4'b0010; exp_grant[2] = 4'b1000;
    exp_id[0]    = 2'd3;    exp_id[1]    = 2'd1;    exp_id[2]    = 2'd3;
    exp_data[0]  = -32'sd5; exp_data[1]  = 32'd2;   exp_data[2]  = -32'sd5;
    @(posedge clk); #1;
    bus.req_data[32*1 +: 32] = 32'd12;     // 12/8 = 1.5 -> 2
    bus.req_exp[6*1 +: 6]    = 6'd3;
    bus.req_data[32*3 +: 32] = -32'sd21;   // -21/4 = -5.25 -> -5
    bus.req_exp[6*3 +: 6]    = 6'd2;
    bus.out_ready            = 1'b1;
    bus.req_valid            = 4'b1010;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k < 3) begin
        checks++;
        if (bus.req_ready !== exp_grant[k]) begin
          errors++;
          $display("FAIL sparse_grant%0d: got %b expected %b", k, bus.req_ready, exp_grant[k]);
        end
      end
      if (k >= 2) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_id !== exp_id[k-2] || bus.out_data !== exp_data[k-2]) begin
          errors++;
          $display("FAIL sparse_out%0d: got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
                   k, bus.out_valid, bus.out_id, bus.out_data, exp_id[k-2], exp_data[k-2]);
        end
      end
      if (k == 2) begin
        @(posedge clk); #1;
        bus.req_valid = '0;
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midflight();
    @(posedge clk); #1;
    bus.req_data[32*0 +: 32] = 32'd77;
    bus.req_exp[6*0 +: 6]    = 6'd0;
    bus.req_data[32*1 +: 32] = 32'd88;
    bus.req_exp[6*1 +: 6]    = 6'd0;
    bus.out_ready            = 1'b0;
    bus.req_valid            = 4'b0011;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.busy !== 1'b1 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_full: v=%b busy=%b ready=%b expected 1 1 0000",
               bus.out_valid, bus.busy, bus.req_ready);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_clear: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
    checks++;
    if (bus.out_data !== 32'd0 || bus.out_id !== 2'd0 || bus.req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL mid_rst_values: data %h id %0d ready %b expected 0 0 0000",
               bus.out_data, bus.out_id, bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_stale: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
    // Requesters 2 and 3 together: the pointer is back at 0, so 2 wins.
    @(posedge clk); #1;
    bus.req_data[32*2 +: 32] = -32'sd100;  // -100/8 = -12.5 -> -13
    bus.req_exp[6*2 +: 6]    = 6'd3;
    bus.req_data[32*3 +: 32] = 32'd5;
    bus.req_exp[6*3 +: 6]    = 6'd0;
    bus.req_valid            = 4'b1100;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL mid_first_grant: got %b expected 0100", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.req_valid = '0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_early: out_valid got %b expected 0", bus.out_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_id !== 2'd2 || bus.out_data !== -32'sd13) begin
      errors++;
      $display("FAIL mid_result: got v=%b id=%0d data=%h expected v=1 id=2 data=%h",
               bus.out_valid, bus.out_id, bus.out_data, -32'sd13);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_empty: out_valid %b busy %b expected 0 0", bus.out_valid, bus.busy);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_round_robin_all();
    test_backpressure();
    test_rr_sparse();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
